// File: rtl/scrambler_pkg.sv
// Shared constants, state type and Gen3 block classifier for the TX scrambler controller.
package scrambler_pkg;

  localparam int unsigned DATA_WIDTH         = 8;
  localparam int unsigned SYMBOL_COUNT_WIDTH = 4;
  localparam int unsigned G12_TS_TAIL        = 14;

  localparam logic [DATA_WIDTH-1:0] SYM_COM       = 8'hBC;
  localparam logic [DATA_WIDTH-1:0] SYM_SKP       = 8'h1C;
  localparam logic [DATA_WIDTH-1:0] SYM_TS1       = 8'h1E;
  localparam logic [DATA_WIDTH-1:0] SYM_TS2       = 8'h2D;
  localparam logic [DATA_WIDTH-1:0] SYM_EIEOS     = 8'h00;
  localparam logic [DATA_WIDTH-1:0] SYM_EIEOS_ODD = 8'hFF;
  localparam logic [DATA_WIDTH-1:0] SYM_SKP_GEN3  = 8'hAA;

  // DC-balance symbols that stay unscrambled at TS symbols 14/15
  localparam logic [DATA_WIDTH-1:0] DCB_SYM14_A = 8'h20;
  localparam logic [DATA_WIDTH-1:0] DCB_SYM14_B = 8'hDF;
  localparam logic [DATA_WIDTH-1:0] DCB_SYM15_A = 8'h08;
  localparam logic [DATA_WIDTH-1:0] DCB_SYM15_B = 8'hF7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_G12_OS_ID,
    ST_G12_SKP,
    ST_G12_TS,
    ST_G12_DATA,
    ST_G3_DATA,
    ST_G3_TS,
    ST_G3_EIEOS,
    ST_G3_SKP,
    ST_G3_OTHER
  } tx_scr_state_e;

  function automatic tx_scr_state_e g3_classify(input logic                  sync_hdr,
                                                input logic [DATA_WIDTH-1:0] sym);
    if (!sync_hdr)                             return ST_G3_DATA;
    if (sym == SYM_TS1 || sym == SYM_TS2)      return ST_G3_TS;
    if (sym == SYM_EIEOS)                      return ST_G3_EIEOS;
    if (sym == SYM_SKP_GEN3)                   return ST_G3_SKP;
    return ST_G3_OTHER;
  endfunction

endpackage

// File: rtl/scr_symbol_counter.sv
// Gen3 symbol-in-block counter: index of the current symbol, advanced per valid symbol.
module scr_symbol_counter
  import scrambler_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          inc_i,
  input  logic                          blk_start_i,
  input  logic                          clr_i,
  output logic [SYMBOL_COUNT_WIDTH-1:0] sym_idx_c_o
);

  logic [SYMBOL_COUNT_WIDTH-1:0] cnt_q;

  // Block_Start resynchronises the current symbol to index 0
  assign sym_idx_c_o = blk_start_i ? '0 : cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= sym_idx_c_o + SYMBOL_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/scrambler_controller_tx.sv
// Per-symbol TX scrambler control (LFSR reset / scramble enable / advance), 1-cycle registered.
// Optional build macro TX_SCRAMBLE_BYPASS_EN adds scramble_disable_i (Gen1/2 scrambling off).
module scrambler_controller_tx
  import scrambler_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          gen_i,
  input  logic                          tx_valid_i,
  input  logic [DATA_WIDTH-1:0]         tx_data_i,
  input  logic                          tx_k_i,
  input  logic                          sync_header_i,
  input  logic                          block_start_i,
`ifdef TX_SCRAMBLE_BYPASS_EN
  input  logic                          scramble_disable_i,
`endif
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  output logic                          tx_valid_o,
  output logic                          sc_lfsr_rst_o,
  output logic                          scramble_enable_o,
  output logic                          advance_o,
  output logic [SYMBOL_COUNT_WIDTH-1:0] count_o
);

  localparam logic [SYMBOL_COUNT_WIDTH-1:0] IDX_DCB14 = SYMBOL_COUNT_WIDTH'(14);
  localparam logic [SYMBOL_COUNT_WIDTH-1:0] IDX_LAST  = SYMBOL_COUNT_WIDTH'(15);

  tx_scr_state_e                 state_q, state_d, cls;
  logic                          gen_q, gen_vld_q, gen_chg;
  logic [SYMBOL_COUNT_WIDTH-1:0] left_q, left_d;
  logic                          eie_ok_q, eie_ok_d;
  logic [SYMBOL_COUNT_WIDTH-1:0] sym_idx;
  logic                          is_com, is_skp;
  logic                          lfsr_rst_d, en_d, adv_d;
  logic [DATA_WIDTH-1:0]         data_q;
  logic                          valid_q, lfsr_rst_q, en_q, adv_q;
  logic [SYMBOL_COUNT_WIDTH-1:0] count_q;

  // A rate change is only meaningful once a GEN value has been seen since reset
  assign gen_chg = gen_vld_q && (gen_i != gen_q);
  assign is_com  = tx_k_i && (tx_data_i == SYM_COM);
  assign is_skp  = tx_k_i && (tx_data_i == SYM_SKP);

  scr_symbol_counter u_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (tx_valid_i && gen_i && !gen_chg),
    .blk_start_i (block_start_i && gen_i),
    .clr_i       (gen_chg),
    .sym_idx_c_o (sym_idx)
  );

  always_comb begin
    state_d    = state_q;
    left_d     = left_q;
    eie_ok_d   = eie_ok_q;
    cls        = state_q;
    lfsr_rst_d = 1'b0;
    en_d       = 1'b0;
    adv_d      = 1'b0;
    if (gen_chg) begin
      state_d = ST_IDLE;
    end else if (tx_valid_i && !gen_i) begin
      if (is_com) begin
        lfsr_rst_d = 1'b1;
        state_d    = ST_G12_OS_ID;
      end else begin
        case (state_q)
          ST_G12_OS_ID: begin
            if (is_skp) begin
              state_d = ST_G12_SKP;
            end else begin
              adv_d   = 1'b1;
              left_d  = SYMBOL_COUNT_WIDTH'(G12_TS_TAIL);
              state_d = ST_G12_TS;
            end
          end
          ST_G12_SKP: begin
            if (!is_skp) begin
              adv_d   = 1'b1;
              en_d    = !tx_k_i;
              state_d = ST_G12_DATA;
            end
          end
          ST_G12_TS: begin
            adv_d  = 1'b1;
            left_d = left_q - SYMBOL_COUNT_WIDTH'(1);
            if (left_q == SYMBOL_COUNT_WIDTH'(1)) state_d = ST_G12_DATA;
          end
          default: begin
            adv_d = 1'b1;
            en_d  = !tx_k_i;
          end
        endcase
      end
`ifdef TX_SCRAMBLE_BYPASS_EN
      if (scramble_disable_i) en_d = 1'b0;
`endif
    end else if (tx_valid_i) begin
      // Symbol 0 reclassifies the block; later symbols inherit the class
      if (sym_idx == '0) cls = g3_classify(sync_header_i, tx_data_i);
      state_d  = cls;
      eie_ok_d = ((sym_idx == '0) || eie_ok_q) &&
                 (tx_data_i == (sym_idx[0] ? SYM_EIEOS_ODD : SYM_EIEOS));
      case (cls)
        ST_G3_TS: begin
          adv_d = 1'b1;
          if (sym_idx == '0)
            en_d = 1'b0;
          else if (sym_idx == IDX_DCB14)
            en_d = !(tx_data_i == DCB_SYM14_A || tx_data_i == DCB_SYM14_B);
          else if (sym_idx == IDX_LAST)
            en_d = !(tx_data_i == DCB_SYM15_A || tx_data_i == DCB_SYM15_B);
          else
            en_d = 1'b1;
        end
        ST_G3_EIEOS: begin
          adv_d      = 1'b1;
          lfsr_rst_d = (sym_idx == IDX_LAST) && eie_ok_d;
        end
        ST_G3_SKP:   ;
        ST_G3_OTHER: adv_d = 1'b1;
        default: begin
          adv_d = 1'b1;
          en_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      gen_q      <= 1'b0;
      gen_vld_q  <= 1'b0;
      left_q     <= '0;
      eie_ok_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      lfsr_rst_q <= 1'b0;
      en_q       <= 1'b0;
      adv_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      gen_q      <= gen_i;
      gen_vld_q  <= 1'b1;
      left_q     <= left_d;
      eie_ok_q   <= eie_ok_d;
      data_q     <= tx_data_i;
      valid_q    <= tx_valid_i && !gen_chg;
      lfsr_rst_q <= lfsr_rst_d;
      en_q       <= en_d;
      adv_q      <= adv_d;
      if (gen_chg)         count_q <= '0;
      else if (tx_valid_i) count_q <= sym_idx;
    end
  end

  assign tx_data_o         = data_q;
  assign tx_valid_o        = valid_q;
  assign sc_lfsr_rst_o     = lfsr_rst_q;
  assign scramble_enable_o = en_q;
  assign advance_o         = adv_q;
  assign count_o           = count_q;

endmodule

// File: tb/tb_scrambler_controller_tx.sv
// Self-checking bench for scrambler_controller_tx against a symbol-level reference model.
module tb_scrambler_controller_tx;

  logic       clk = 1'b0;
  logic       rst, gen, valid, k, sh, bs;
  logic [7:0] data;
  logic [7:0] o_data;
  logic       o_v, o_rst, o_en, o_adv;
  logic [3:0] o_cnt;
`ifdef TX_SCRAMBLE_BYPASS_EN
  logic       scr_dis = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // reference model state: phase 0 data/idle, 1 after COM, 2 in SKP OS, 3 in TS OS
  bit         m_gen_known, m_gen, m_eie_good;
  int         m_phase, m_ts_seen, m_pos, m_kind;  // kind 0 data,1 ts,2 eieos,3 skp,4 other
  logic       e_v, e_r, e_e, e_a;
  logic [7:0] e_d;
  logic [3:0] e_cnt;

  always #5 clk = ~clk;

  scrambler_controller_tx dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .gen_i             (gen),
    .tx_valid_i        (valid),
    .tx_data_i         (data),
    .tx_k_i            (k),
    .sync_header_i     (sh),
    .block_start_i     (bs),
`ifdef TX_SCRAMBLE_BYPASS_EN
    .scramble_disable_i(scr_dis),
`endif
    .tx_data_o         (o_data),
    .tx_valid_o        (o_v),
    .sc_lfsr_rst_o     (o_rst),
    .scramble_enable_o (o_en),
    .advance_o         (o_adv),
    .count_o           (o_cnt)
  );

  task automatic model_step(input bit g, input bit v, input logic [7:0] d, input bit kk,
                            input bit s, input bit b, input bit r);
    int idx;
    e_v = 0; e_r = 0; e_e = 0; e_a = 0; e_d = d;
    if (r) begin
      m_gen_known = 0; m_phase = 0; m_pos = 0; m_kind = 0; m_eie_good = 0;
      e_d = 8'h00; e_cnt = 4'd0;
      return;
    end
    if (m_gen_known && g != m_gen) begin
      m_gen = g; m_phase = 0; m_pos = 0; m_kind = 0; e_cnt = 4'd0;
      return;
    end
    m_gen_known = 1; m_gen = g;
    if (!v) return;
    e_v = 1;
    if (!g) begin
      e_cnt = 4'd0;
      if (kk && d == 8'hBC) begin
        e_r = 1; m_phase = 1;
      end else if (m_phase == 1) begin
        if (kk && d == 8'h1C) m_phase = 2;
        else begin e_a = 1; m_phase = 3; m_ts_seen = 2; end
      end else if (m_phase == 2 && kk && d == 8'h1C) begin
      end else if (m_phase == 3) begin
        e_a = 1; m_ts_seen++;
        if (m_ts_seen == 16) m_phase = 0;
      end else begin
        e_a = 1; e_e = !kk; m_phase = 0;
      end
`ifdef TX_SCRAMBLE_BYPASS_EN
      if (scr_dis) e_e = 0;
`endif
    end else begin
      idx = b ? 0 : m_pos;
      m_pos = (idx + 1) % 16;
      e_cnt = 4'(idx);
      if (idx == 0) begin
        m_eie_good = 1;
        if (!s)                        m_kind = 0;
        else if (d == 8'h1E || d == 8'h2D) m_kind = 1;
        else if (d == 8'h00)           m_kind = 2;
        else if (d == 8'hAA)           m_kind = 3;
        else                           m_kind = 4;
      end
      m_eie_good = m_eie_good && (d == ((idx % 2) ? 8'hFF : 8'h00));
      case (m_kind)
        1: begin
          e_a = 1;
          if (idx == 0)       e_e = 0;
          else if (idx == 14) e_e = !(d == 8'h20 || d == 8'hDF);
          else if (idx == 15) e_e = !(d == 8'h08 || d == 8'hF7);
          else                e_e = 1;
        end
        2: begin e_a = 1; e_r = (idx == 15) && m_eie_good; end
        3: ;
        4: e_a = 1;
        default: begin e_a = 1; e_e = 1; end
      endcase
    end
  endtask

  // Apply one symbol, let one active edge pass, sample 1 time unit later
  task automatic send(input bit g, input bit v, input logic [7:0] d, input bit kk,
                      input bit s, input bit b, input bit r);
    gen = g; valid = v; data = d; k = kk; sh = s; bs = b; rst = r;
    @(posedge clk);
    #1;
    model_step(g, v, d, kk, s, b, r);
  endtask

  task automatic test_reset();
    send(0, 0, 8'h00, 0, 0, 0, 1);
    send(0, 1, 8'hBC, 1, 0, 0, 1);
    vectors++;
    if ({o_data, o_v, o_rst, o_en, o_adv, o_cnt} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_state: got d=%h v%b r%b e%b a%b c%0d, want all 0",
               o_data, o_v, o_rst, o_en, o_adv, o_cnt);
    end
  endtask

  task automatic test_g12_ts();
    logic [7:0] s;
    logic [15:0] env;
    env = '0;
    for (int i = 0; i < 19; i++) begin
      s = (i == 0) ? 8'hBC : (i == 1) ? 8'h01 : (i < 16) ? 8'($urandom_range(1, 255)) : 8'h00;
      send(0, 1, s, (i == 0), 0, 0, 0);
      if (i < 16) env[i] = o_en;
      vectors++;
      if ({o_v, o_rst, o_en, o_adv, o_data, o_cnt} !== {e_v, e_r, e_e, e_a, e_d, e_cnt}) begin
        miscompares++;
        $display("FAIL g12_ts sym%0d: got v%b r%b e%b a%b d=%h, want v%b r%b e%b a%b d=%h",
                 i, o_v, o_rst, o_en, o_adv, o_data, e_v, e_r, e_e, e_a, e_d);
      end
      if (i == 0) begin
        vectors++;
        if (o_rst !== 1'b1) begin miscompares++; $display("FAIL g12_com_rst: got %b want 1", o_rst); end
      end
      if (i == 17) begin
        vectors++;
        if (o_en !== 1'b1) begin miscompares++; $display("FAIL g12_idle_en: got %b want 1", o_en); end
      end
    end
    vectors++;
    if (env !== 16'h0000) begin miscompares++; $display("FAIL g12_os_en: got %h want 0000", env); end
  endtask

  task automatic test_g12_skp();
    logic [7:0] s [5] = '{8'hBC, 8'h1C, 8'h1C, 8'h1C, 8'h4A};
    logic [4:0] advv, env;
    for (int i = 0; i < 5; i++) begin
      send(0, 1, s[i], (i < 4), 0, 0, 0);
      advv[i] = o_adv; env[i] = o_en;
      vectors++;
      if ({o_v, o_rst, o_en, o_adv, o_data} !== {e_v, e_r, e_e, e_a, e_d}) begin
        miscompares++;
        $display("FAIL g12_skp sym%0d: got r%b e%b a%b, want r%b e%b a%b",
                 i, o_rst, o_en, o_adv, e_r, e_e, e_a);
      end
    end
    vectors++;
    if (advv !== 5'b10000 || env !== 5'b10000) begin
      miscompares++;
      $display("FAIL g12_skp_pattern: got adv=%b en=%b, want 10000/10000", advv, env);
    end
  endtask

  task automatic test_g3_ts();
    logic [7:0] s;
    logic [15:0] env, advv;
    send(1, 0, 8'h00, 0, 0, 0, 0);  // rate change cycle
    vectors++;
    if ({o_v, o_en, o_adv} !== 3'b000) begin miscompares++; $display("FAIL gen_change: got v%b e%b a%b want 000", o_v, o_en, o_adv); end
    for (int i = 0; i < 16; i++) begin
      s = (i == 0) ? 8'h1E : (i == 14) ? 8'h20 : (i == 15) ? 8'h5A : 8'($urandom);
      send(1, 1, s, 0, 1, (i == 0), 0);
      env[i] = o_en; advv[i] = o_adv;
      vectors++;
      if ({o_v, o_rst, o_en, o_adv, o_cnt} !== {e_v, e_r, e_e, e_a, e_cnt}) begin
        miscompares++;
        $display("FAIL g3_ts sym%0d: got e%b a%b c%0d, want e%b a%b c%0d",
                 i, o_en, o_adv, o_cnt, e_e, e_a, e_cnt);
      end
    end
    vectors++;
    if (env !== 16'hBFFE || advv !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL g3_ts_pattern: got en=%h adv=%h, want BFFE/FFFF", env, advv);
    end
  endtask

  task automatic test_g3_eieos();
    logic [7:0] s;
    logic [15:0] rstv;
    for (int pass = 0; pass < 2; pass++) begin
      rstv = '0;
      for (int i = 0; i < 16; i++) begin
        s = (i % 2) ? 8'hFF : 8'h00;
        if (pass == 1 && i == 7) s = 8'hFE;
        send(1, 1, s, 0, 1, (i == 0), 0);
        rstv[i] = o_rst;
        vectors++;
        if ({o_v, o_rst, o_en, o_adv, o_cnt} !== {e_v, e_r, e_e, e_a, e_cnt}) begin
          miscompares++;
          $display("FAIL g3_eieos p%0d sym%0d: got r%b e%b a%b, want r%b e%b a%b",
                   pass, i, o_rst, o_en, o_adv, e_r, e_e, e_a);
        end
      end
      vectors++;
      if (rstv !== ((pass == 0) ? 16'h8000 : 16'h0000)) begin
        miscompares++;
        $display("FAIL g3_eieos_rst p%0d: got %h want %h", pass, rstv, (pass == 0) ? 16'h8000 : 16'h0000);
      end
    end
  endtask

  task automatic test_g3_skp_gaps();
    int i;
    bit v;
    for (int j = 0; j < 16; j++) begin
      send(1, 1, (j == 0) ? 8'hAA : 8'hAA, 0, 1, (j == 0), 0);
      vectors++;
      if ({o_v, o_en, o_adv, o_cnt} !== {e_v, e_e, e_a, e_cnt} || o_adv !== 1'b0) begin
        miscompares++;
        $display("FAIL g3_skp sym%0d: got e%b a%b c%0d, want e%b a0 c%0d", j, o_en, o_adv, o_cnt, e_e, e_cnt);
      end
    end
    i = 0;
    while (i < 16) begin
      v = ($urandom_range(0, 2) != 0);
      send(1, v, 8'($urandom), 0, 0, (v && i == 0), 0);
      vectors++;
      if ({o_v, o_rst, o_en, o_adv, o_cnt} !== {e_v, e_r, e_e, e_a, e_cnt}) begin
        miscompares++;
        $display("FAIL g3_data_gap sym%0d v%b: got v%b e%b a%b c%0d, want v%b e%b a%b c%0d",
                 i, v, o_v, o_en, o_adv, o_cnt, e_v, e_e, e_a, e_cnt);
      end
      if (v) i++;
    end
  endtask

  task automatic test_mid_block_disrupt();
    logic [7:0] s;
    for (int i = 0; i < 6; i++) send(1, 1, (i == 0) ? 8'h1E : 8'h33, 0, 1, (i == 0), 0);
    send(1, 1, 8'h33, 0, 1, 0, 1);
    vectors++;
    if ({o_v, o_rst, o_en, o_adv, o_cnt} !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset: got v%b r%b e%b a%b c%0d, want all 0", o_v, o_rst, o_en, o_adv, o_cnt);
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        s = (i == 0) ? ((pass == 0) ? 8'h2D : 8'h00) : (pass == 1) ? ((i % 2) ? 8'hFF : 8'h00) : 8'h44;
        send(1, 1, s, 0, 1, (i == 0), 0);
        vectors++;
        if ({o_v, o_rst, o_en, o_adv, o_cnt} !== {e_v, e_r, e_e, e_a, e_cnt}) begin
          miscompares++;
          $display("FAIL post_disrupt p%0d sym%0d: got r%b e%b a%b c%0d, want r%b e%b a%b c%0d",
                   pass, i, o_rst, o_en, o_adv, o_cnt, e_r, e_e, e_a, e_cnt);
        end
        if (pass == 0 && i == 5) begin
          send(0, 1, 8'hBC, 1, 0, 0, 0);  // rate drop mid-block
          vectors++;
          if ({o_v, o_rst, o_en, o_adv, o_cnt} !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_gen_change: got v%b r%b e%b a%b c%0d, want all 0", o_v, o_rst, o_en, o_adv, o_cnt);
          end
          send(0, 1, 8'h12, 0, 0, 0, 0);
          vectors++;
          if ({o_v, o_en, o_adv} !== 3'b111) begin
            miscompares++;
            $display("FAIL idle_as_data: got v%b e%b a%b, want 111", o_v, o_en, o_adv);
          end
          send(1, 0, 8'h00, 0, 0, 0, 0);
          break;
        end
      end
    end
  endtask

  task automatic test_random();
    bit g, v, kk, s, b, r;
    logic [7:0] d;
    int pick;
    g = 1;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) g = !g;
      r = ($urandom_range(0, 149) == 0);
      v = ($urandom_range(0, 6) != 0);
`ifdef TX_SCRAMBLE_BYPASS_EN
      scr_dis = ($urandom_range(0, 3) == 0);
`endif
      pick = $urandom_range(0, 4);
      kk = 0; s = $urandom_range(0, 3) != 0; b = 0;
      if (!g) begin
        case (pick)
          0: begin d = 8'hBC; kk = 1; end
          1: begin d = 8'h1C; kk = 1; end
          2: begin d = 8'($urandom); kk = 1; end
          3: d = 8'h00;
          default: d = 8'($urandom);
        endcase
      end else begin
        b = (m_pos == 0) || ($urandom_range(0, 39) == 0);
        if (b) begin
          case (pick)
            0: d = 8'h1E;
            1: d = 8'h2D;
            2: d = 8'h00;
            3: d = 8'hAA;
            default: d = 8'($urandom);
          endcase
        end else if (m_kind == 2 && pick != 0) begin
          d = (m_pos % 2) ? 8'hFF : 8'h00;
        end else begin
          case (pick)
            0: d = 8'h20;
            1: d = 8'hDF;
            2: d = 8'h08;
            3: d = 8'hF7;
            default: d = 8'($urandom);
          endcase
        end
      end
      send(g, v, d, kk, s, b, r);
      vectors++;
      if ({o_v, o_rst, o_en, o_adv, o_data, o_cnt} !== {e_v, e_r, e_e, e_a, e_d, e_cnt}) begin
        miscompares++;
        $display("FAIL random n%0d g%0d: got v%b r%b e%b a%b d=%h c%0d, want v%b r%b e%b a%b d=%h c%0d",
                 n, g, o_v, o_rst, o_en, o_adv, o_data, o_cnt, e_v, e_r, e_e, e_a, e_d, e_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; gen = 1'b0; valid = 1'b0; data = 8'h00; k = 1'b0; sh = 1'b0; bs = 1'b0;
    test_reset();
    test_g12_ts();
    test_g12_skp();
    test_g3_ts();
    test_g3_eieos();
    test_g3_skp_gaps();
    test_mid_block_disrupt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
